// File: rtl/arith_pkg.sv
// arith_pkg: definitions shared by the arithmetic-unit blocks.
//   state_t       control FSM encoding of the sequential divider
//   DEFAULT_WIDTH operand width shared with the multiplier datapath
//   clog2()       ceiling log2, used to size step counters
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Number of bits needed to hold the values 0 .. n-1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
//   p      in   partial remainder (WIDTH+1 bits) before the shift
//   q_msb  in   MSB of the quotient/dividend shift register, shifted into p
//   d      in   divisor
//   p_next out  partial remainder after the trial subtraction
//   q_bit  out  quotient bit produced by this iteration
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   p_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Shift in the next dividend bit and try to subtract the divisor. The
  // subtraction is one bit wider than P so the sign bit never aliases data,
  // even though P stays below 2**WIDTH in normal operation.
  always_comb begin
    shifted = {p, q_msb};
    trial   = shifted - {2'b00, d};
    if (trial[WIDTH+1] == 1'b0) begin
      p_next = trial[WIDTH:0];
      q_bit  = 1'b1;
    end else begin
      p_next = shifted[WIDTH:0];
      q_bit  = 1'b0;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential radix-2 restoring unsigned divider, one quotient
// bit per clock, with START/BUSY/DONE handshake.
//   CLK          in   rising-edge clock
//   RST          in   synchronous active-high reset
//   START        in   request, sampled only while idle
//   DIVIDEND     in   numerator, captured on the accepting edge
//   DIVISOR      in   denominator, captured on the accepting edge
//   BUSY         out  high while iterating
//   DONE         out  one-cycle pulse, results valid from this cycle on
//   QUOTIENT     out  registered quotient (all-ones on divide by zero)
//   REMAINDER    out  registered remainder (dividend on divide by zero)
//   DIV_BY_ZERO  out  high when the last accepted divisor was zero
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             DIV_BY_ZERO
);

  localparam int CW = clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;

  logic [WIDTH:0]   p_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_reg),
    .q_msb  (q_reg[WIDTH-1]),
    .d      (d_reg),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  assign q_next = {q_reg[WIDTH-2:0], q_bit};

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      p_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      QUOTIENT    <= '0;
      REMAINDER   <= '0;
      DIV_BY_ZERO <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            p_reg <= '0;
            q_reg <= DIVIDEND;
            d_reg <= DIVISOR;
            cnt   <= CW'(WIDTH - 1);
            if (DIVISOR == '0) begin
              // Results are known immediately; DONE follows one edge later
              // from FIN, keyed off the flag loaded here.
              state       <= FIN;
              QUOTIENT    <= '1;
              REMAINDER   <= DIVIDEND;
              DIV_BY_ZERO <= 1'b1;
            end else begin
              state <= RUN;
              BUSY  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          p_reg <= p_next;
          q_reg <= q_next;
          if (cnt == '0) begin
            // Last iteration: publish the results of this very step.
            state       <= FIN;
            BUSY        <= 1'b0;
            DONE        <= 1'b1;
            QUOTIENT    <= q_next;
            REMAINDER   <= p_next[WIDTH-1:0];
            DIV_BY_ZERO <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        FIN: begin
          // A normal divide pulsed DONE on entry; a divide by zero pulses
          // it on exit.
          state <= IDLE;
          DONE  <= DIV_BY_ZERO;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider (WIDTH = 8). Stimulus
// pushes hand-computed expectations; a forked monitor pops one entry per
// DONE pulse and checks values and the edge on which DONE appeared.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  seq_divider #(.WIDTH(W)) dut (
    .CLK         (clk),
    .RST         (rst),
    .START       (start),
    .DIVIDEND    (dividend),
    .DIVISOR     (divisor),
    .BUSY        (busy),
    .DONE        (done),
    .QUOTIENT    (quotient),
    .REMAINDER   (remainder),
    .DIV_BY_ZERO (dbz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("quotient", 32'(quotient), 32'(e.q));
          check("remainder", 32'(remainder), 32'(e.r));
          check("div_by_zero", 32'(dbz), 32'(e.dz));
          check("done_edge", 32'(cyc), 32'(e.cyc));
          if (e.b != '0) begin
            check("inv_q_d_plus_r", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
            check("inv_r_lt_d", 32'(remainder < e.b), 32'd1);
          end
        end
      end
    end
  endtask

  // Drive one request for a single edge; optionally register its expectation.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic push,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    if (push) begin
      e.q   = eq;
      e.r   = er;
      e.dz  = edz;
      e.a   = a;
      e.b   = b;
      e.cyc = cyc + (edz ? 1 : W);
      sb.push_back(e);
    end
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           t;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(dbz), 32'd0);

    // 100/7: BUSY for exactly W cycles
    start_op(8'd100, 8'd7, 1'b1, 8'd14, 8'd2, 1'b0);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("busy_run", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("busy_after_run", 32'(busy), 32'd0);
    @(posedge clk);

    // Divisor 1 and divisor larger than dividend
    start_op(8'd255, 8'd1, 1'b1, 8'd255, 8'd0, 1'b0);
    repeat (W + 1) @(posedge clk);
    start_op(8'd3, 8'd200, 1'b1, 8'd0, 8'd3, 1'b0);
    repeat (W + 1) @(posedge clk);

    // Divide by zero, then a normal divide clears the flag
    start_op(8'd5, 8'd0, 1'b1, 8'd255, 8'd5, 1'b1);
    @(negedge clk);
    check("dbz_busy0", 32'(busy), 32'd0);
    @(negedge clk);
    check("dbz_busy1", 32'(busy), 32'd0);
    start_op(8'd9, 8'd3, 1'b1, 8'd3, 8'd0, 1'b0);
    repeat (W + 1) @(posedge clk);

    // START during RUN is ignored; results hold afterwards
    start_op(8'd200, 8'd9, 1'b1, 8'd22, 8'd2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 8'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (W - 1) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("hold_quotient", 32'(quotient), 32'd22);
    check("hold_remainder", 32'(remainder), 32'd2);
    check("hold_dbz", 32'(dbz), 32'd0);

    // Reset four edges into a running divide
    start_op(8'd200, 8'd9, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dbz", 32'(dbz), 32'd0);
    @(posedge clk);
    start_op(8'd17, 8'd4, 1'b1, 8'd4, 8'd1, 1'b0);
    repeat (W + 1) @(posedge clk);

    // Random sweep at minimum spacing, reference model in the bench
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom_range(0, 255));
      b = (i % 50 == 7) ? 8'd0 : W'($urandom_range(1, 255));
      if (b == '0) begin
        start_op(a, b, 1'b1, 8'd255, a, 1'b1);
        @(posedge clk);
      end else begin
        start_op(a, b, 1'b1, a / b, a % b, 1'b0);
        repeat (W + 1) @(posedge clk);
      end
    end

    // Drain: every expected DONE must have been seen
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
